reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file for the CPU datapath. It provides DATA_W-bit storage with three asynchronous read ports and two synchronous write ports, and supports optional write-to-read bypass and a hardwired-zero register 0. A per-register busy scoreboard is set at issue and cleared on writeback, so the decode stage can detect pending operands.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1: register 0 reads as 0, writes to it are dropped, it is never busy
- BYPASS, 1, when 1: same-cycle write data and busy-clear are forwarded to read ports
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr0_en  in  1  write port 0 enable (ALU writeback)
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable (load writeback); wins over port 0 on address collision
- wr1_addr  in  ADDR_W  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- busy_set_en  in  1  mark busy_set_addr pending (instruction issue)
- busy_set_addr  in  ADDR_W  register to mark busy
- rd0_addr, rd1_addr, rd2_addr  in  ADDR_W  read addresses
- rd0_data, rd1_data, rd2_data  out  DATA_W  read data, combinational
- rd0_busy, rd1_busy, rd2_busy  out  1  operand-pending flags, combinational

## Operation
- Storage: mem[DEPTH] of DATA_W bits, busy[DEPTH] of 1 bit.
- Write: on posedge with rst=0, each enabled port writes mem[addr] <= data. If both ports target the same address, wr1_data is stored. Writes to address 0 are dropped when ZERO_REG=1.
- Busy clear: each enabled write clears busy[addr].
- Busy set: busy_set_en sets busy[busy_set_addr]. If a set and a clear hit the same register in the same cycle, the set wins (new producer issued). Setting register 0 is ignored when ZERO_REG=1.
- Read data, evaluated in this order:
  - ZERO_REG=1 and addr=0 → 0.
  - Else if BYPASS=1, rst=0, wr1_en and wr1_addr=addr → wr1_data.
  - Else if BYPASS=1, rst=0, wr0_en and wr0_addr=addr → wr0_data.
  - Else → mem[addr].
- Read busy:
  - busy[addr].
  - Forced 0 if ZERO_REG=1 and addr=0.
  - Forced 0 if BYPASS=1, rst=0 and any enabled write targets addr this cycle.
  - busy_set_en in the same cycle never affects the read flags; it is visible from the next cycle.
- Reset: on posedge with rst=1, all mem entries are set to 0 and all busy bits to 0. Writes and busy sets presented in that cycle are ignored.

## Timing
- Read latency: 0 cycles (combinational from address). A write becomes visible through mem on the cycle after its edge, or in the same cycle via bypass when BYPASS=1.
- Reset values: after the reset edge every rd*_data reads 0 and every rd*_busy reads 0. While rst=1, outputs show the stored contents with bypass suppressed.
- Reset asserted mid-operation: pending writes and busy sets in the rst cycle are discarded; no partial state remains.
- No handshake; every request is accepted every cycle. Address ranges are always full (DEPTH = 2**ADDR_W), so no out-of-range case exists.

## Test plan
- Reset: write mem[5]=0xDEADBEEF, set busy[5], then assert rst for 1 cycle → rd0_addr=5 gives rd0_data=0 and rd0_busy=0.
- Dual-write collision: wr0 (addr 7, 0x11) and wr1 (addr 7, 0x22) in the same cycle → next cycle rd1_data=0x22. Different addresses 3/4 → both stored.
- Bypass: BYPASS=1, wr0 (addr 9, 0xA5A5) with rd2_addr=9 in the same cycle → rd2_data=0xA5A5 combinationally. With BYPASS=0 → old value until the next cycle.
- Zero register: ZERO_REG=1, wr1 (addr 0, 0xFFFF_FFFF) plus busy_set on addr 0 → rd0_data=0, rd0_busy=0 on all later cycles.
- Scoreboard: busy_set addr 12 → rd1_busy=1 next cycle. Then wr0 addr 12 → rd1_busy=0 the same cycle (BYPASS=1), and busy[12]=0 afterwards.
- Set/clear race: busy_set addr 6 together with wr1 addr 6 → busy[6]=1 next cycle and mem[6]=wr1_data.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file: three combinational read ports, two synchronous write ports,
// optional write-to-read bypass, hardwired-zero r0 and a per-register busy scoreboard.
module reg_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr0_en,
  input  logic [ADDR_W-1:0] i_wr0_addr,
  input  logic [DATA_W-1:0] i_wr0_data,
  input  logic              i_wr1_en,
  input  logic [ADDR_W-1:0] i_wr1_addr,
  input  logic [DATA_W-1:0] i_wr1_data,
  input  logic              i_busy_set_en,
  input  logic [ADDR_W-1:0] i_busy_set_addr,
  input  logic [ADDR_W-1:0] i_rd0_addr,
  input  logic [ADDR_W-1:0] i_rd1_addr,
  input  logic [ADDR_W-1:0] i_rd2_addr,
  output logic [DATA_W-1:0] o_rd0_data,
  output logic [DATA_W-1:0] o_rd1_data,
  output logic [DATA_W-1:0] o_rd2_data,
  output logic              o_rd0_busy,
  output logic              o_rd1_busy,
  output logic              o_rd2_busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam bit HasZero = (ZERO_REG != 0);
  localparam bit HasByp  = (BYPASS != 0);

  logic [DATA_W-1:0] r_mem [Depth];
  logic [Depth-1:0]  r_busy;
  logic [Depth-1:0]  w_busy_next;
  logic              w_wr0_ok;
  logic              w_wr1_ok;
  logic              w_set_ok;
  logic              w_byp_on;

  assign w_wr0_ok = i_wr0_en && !(HasZero && (i_wr0_addr == '0));
  assign w_wr1_ok = i_wr1_en && !(HasZero && (i_wr1_addr == '0));
  assign w_set_ok = i_busy_set_en && !(HasZero && (i_busy_set_addr == '0));
  assign w_byp_on = HasByp && !i_rst;

  // Clears first, then the set, so a newly issued producer wins over a writeback.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wr0_ok) w_busy_next[i_wr0_addr] = 1'b0;
    if (w_wr1_ok) w_busy_next[i_wr1_addr] = 1'b0;
    if (w_set_ok) w_busy_next[i_busy_set_addr] = 1'b1;
  end

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        r_mem[i[ADDR_W-1:0]] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr0_ok) r_mem[i_wr0_addr] <= i_wr0_data;
      if (w_wr1_ok) r_mem[i_wr1_addr] <= i_wr1_data;
      r_busy <= w_busy_next;
    end
  end

  logic [ADDR_W-1:0] w_rd_addr [3];
  logic [DATA_W-1:0] w_rd_data [3];
  logic              w_rd_busy [3];

  assign w_rd_addr[0] = i_rd0_addr;
  assign w_rd_addr[1] = i_rd1_addr;
  assign w_rd_addr[2] = i_rd2_addr;

  for (genvar p = 0; p < 3; p++) begin : g_rd
    logic w_hit0;
    logic w_hit1;
    assign w_hit0 = w_byp_on && i_wr0_en && (i_wr0_addr == w_rd_addr[p]);
    assign w_hit1 = w_byp_on && i_wr1_en && (i_wr1_addr == w_rd_addr[p]);

    always_comb begin
      w_rd_data[p] = r_mem[w_rd_addr[p]];
      w_rd_busy[p] = r_busy[w_rd_addr[p]];
      if (HasZero && (w_rd_addr[p] == '0)) begin
        w_rd_data[p] = '0;
        w_rd_busy[p] = 1'b0;
      end else if (w_hit1) begin
        w_rd_data[p] = i_wr1_data;
        w_rd_busy[p] = 1'b0;
      end else if (w_hit0) begin
        w_rd_data[p] = i_wr0_data;
        w_rd_busy[p] = 1'b0;
      end
    end
  end

  assign o_rd0_data = w_rd_data[0];
  assign o_rd1_data = w_rd_data[1];
  assign o_rd2_data = w_rd_data[2];
  assign o_rd0_busy = w_rd_busy[0];
  assign o_rd1_busy = w_rd_busy[1];
  assign o_rd2_busy = w_rd_busy[2];

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (zero-reg+bypass, and neither) driven by shared
// stimulus and compared against an array-based reference model of the register file.
module tb_reg_file_mp;

  logic        clk;
  logic        rst;
  logic        wr0_en, wr1_en, busy_set_en;
  logic [4:0]  wr0_addr, wr1_addr, busy_set_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [4:0]  rd_addr [3];
  logic [31:0] rd_data [2][3];
  logic        rd_busy [2][3];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: index 0 models the ZERO_REG=1/BYPASS=1 instance, index 1 the 0/0 one.
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
    .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
    .i_busy_set_en(busy_set_en), .i_busy_set_addr(busy_set_addr),
    .i_rd0_addr(rd_addr[0]), .i_rd1_addr(rd_addr[1]), .i_rd2_addr(rd_addr[2]),
    .o_rd0_data(rd_data[0][0]), .o_rd1_data(rd_data[0][1]), .o_rd2_data(rd_data[0][2]),
    .o_rd0_busy(rd_busy[0][0]), .o_rd1_busy(rd_busy[0][1]), .o_rd2_busy(rd_busy[0][2])
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
    .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
    .i_busy_set_en(busy_set_en), .i_busy_set_addr(busy_set_addr),
    .i_rd0_addr(rd_addr[0]), .i_rd1_addr(rd_addr[1]), .i_rd2_addr(rd_addr[2]),
    .o_rd0_data(rd_data[1][0]), .o_rd1_data(rd_data[1][1]), .o_rd2_data(rd_data[1][2]),
    .o_rd0_busy(rd_busy[1][0]), .o_rd1_busy(rd_busy[1][1]), .o_rd2_busy(rd_busy[1][2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit has_zero(int k);
    return k == 0;
  endfunction

  function automatic bit has_byp(int k);
    return k == 0;
  endfunction

  function automatic logic [31:0] exp_data(int k, logic [4:0] a);
    if (has_zero(k) && a == 0) return 32'h0;
    if (has_byp(k) && !rst && wr1_en && wr1_addr == a) return wr1_data;
    if (has_byp(k) && !rst && wr0_en && wr0_addr == a) return wr0_data;
    return m_mem[k][a];
  endfunction

  function automatic bit exp_busy(int k, logic [4:0] a);
    if (has_zero(k) && a == 0) return 1'b0;
    if (has_byp(k) && !rst && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a)))
      return 1'b0;
    return m_busy[k][a];
  endfunction

  // Apply one clock edge to the model: writes in port order, then the busy set.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          m_mem[k][r]  = 32'h0;
          m_busy[k][r] = 1'b0;
        end
      end else begin
        if (wr0_en && !(has_zero(k) && wr0_addr == 0)) begin
          m_mem[k][wr0_addr]  = wr0_data;
          m_busy[k][wr0_addr] = 1'b0;
        end
        if (wr1_en && !(has_zero(k) && wr1_addr == 0)) begin
          m_mem[k][wr1_addr]  = wr1_data;
          m_busy[k][wr1_addr] = 1'b0;
        end
        if (busy_set_en && !(has_zero(k) && busy_set_addr == 0))
          m_busy[k][busy_set_addr] = 1'b1;
      end
    end
  endtask

  task automatic settle(input bit do_chk);
    #4;
    if (do_chk) begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 3; p++) begin
          check($sformatf("d%0d_rd%0d_data", k, p), rd_data[k][p], exp_data(k, rd_addr[p]));
          check($sformatf("d%0d_rd%0d_busy", k, p), {31'h0, rd_busy[k][p]},
                {31'h0, exp_busy(k, rd_addr[p])});
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; busy_set_en = 1'b0;
    wr0_addr = '0; wr1_addr = '0; busy_set_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    idle();
    for (int p = 0; p < 3; p++) rd_addr[p] = '0;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) begin
        m_mem[k][r] = 32'h0;
        m_busy[k][r] = 1'b0;
      end
    rst = 1'b1;
    settle(1'b0); tick();
    settle(1'b0); tick();

    // Reset clears a written, busy register.
    idle(); wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    busy_set_en = 1; busy_set_addr = 5;
    settle(1'b1); tick();
    idle(); rst = 1'b1; rd_addr[0] = 5;
    settle(1'b1); tick();
    idle(); rd_addr[0] = 5;
    settle(1'b1);
    check("reset_data", rd_data[0][0], 32'h0);
    check("reset_busy", {31'h0, rd_busy[0][0]}, 32'h0);
    tick();

    // Write-port collision and independent writes.
    idle(); wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22;
    settle(1'b1); tick();
    idle(); rd_addr[1] = 7;
    settle(1'b1);
    check("collide_a", rd_data[0][1], 32'h22);
    check("collide_b", rd_data[1][1], 32'h22);
    tick();
    idle(); wr0_en = 1; wr0_addr = 3; wr0_data = 32'hA3;
    wr1_en = 1; wr1_addr = 4; wr1_data = 32'hB4;
    settle(1'b1); tick();
    idle(); rd_addr[0] = 3; rd_addr[1] = 4;
    settle(1'b1);
    check("dual_wr0", rd_data[0][0], 32'hA3);
    check("dual_wr1", rd_data[1][1], 32'hB4);
    tick();

    // Bypass versus no-bypass.
    idle(); wr0_en = 1; wr0_addr = 9; wr0_data = 32'hA5A5; rd_addr[2] = 9;
    settle(1'b1);
    check("bypass_on", rd_data[0][2], 32'hA5A5);
    check("bypass_off", rd_data[1][2], 32'h0);
    tick();
    idle(); rd_addr[2] = 9;
    settle(1'b1);
    check("nobyp_next", rd_data[1][2], 32'hA5A5);
    tick();

    // Register 0: hardwired on instance a, ordinary on instance b.
    idle(); wr1_en = 1; wr1_addr = 0; wr1_data = 32'hFFFF_FFFF;
    busy_set_en = 1; busy_set_addr = 0; rd_addr[0] = 0;
    settle(1'b1); tick();
    idle(); rd_addr[0] = 0;
    settle(1'b1);
    check("zero_data", rd_data[0][0], 32'h0);
    check("zero_busy", {31'h0, rd_busy[0][0]}, 32'h0);
    check("r0_data_b", rd_data[1][0], 32'hFFFF_FFFF);
    check("r0_busy_b", {31'h0, rd_busy[1][0]}, 32'h1);
    tick();

    // Scoreboard set, bypassed clear, settled clear.
    idle(); busy_set_en = 1; busy_set_addr = 12;
    settle(1'b1); tick();
    idle(); rd_addr[1] = 12;
    settle(1'b1);
    check("sb_set", {31'h0, rd_busy[0][1]}, 32'h1);
    tick();
    idle(); wr0_en = 1; wr0_addr = 12; wr0_data = 32'h1234; rd_addr[1] = 12;
    settle(1'b1);
    check("sb_byp_clr", {31'h0, rd_busy[0][1]}, 32'h0);
    check("sb_nobyp", {31'h0, rd_busy[1][1]}, 32'h1);
    tick();
    idle(); rd_addr[1] = 12;
    settle(1'b1);
    check("sb_clr_a", {31'h0, rd_busy[0][1]}, 32'h0);
    check("sb_clr_b", {31'h0, rd_busy[1][1]}, 32'h0);
    tick();

    // Set and clear racing on the same register.
    idle(); busy_set_en = 1; busy_set_addr = 6; wr1_en = 1; wr1_addr = 6; wr1_data = 32'h66;
    settle(1'b1); tick();
    idle(); rd_addr[0] = 6;
    settle(1'b1);
    check("race_busy", {31'h0, rd_busy[0][0]}, 32'h1);
    check("race_data", rd_data[0][0], 32'h66);
    tick();

    // Reset arriving with a write and busy set pending.
    idle(); rst = 1; wr0_en = 1; wr0_addr = 10; wr0_data = 32'h77;
    busy_set_en = 1; busy_set_addr = 10; rd_addr[0] = 10;
    settle(1'b1); tick();
    idle(); rd_addr[0] = 10; rd_addr[1] = 6;
    settle(1'b1);
    check("midrst_data", rd_data[0][0], 32'h0);
    check("midrst_busy", {31'h0, rd_busy[0][0]}, 32'h0);
    check("midrst_r6", rd_data[1][1], 32'h0);
    tick();

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 59) == 0);
      wr0_en        = 1'($urandom_range(0, 1));
      wr1_en        = 1'($urandom_range(0, 1));
      busy_set_en   = 1'($urandom_range(0, 1));
      wr0_addr      = rand_addr();
      wr1_addr      = rand_addr();
      busy_set_addr = rand_addr();
      wr0_data      = $urandom();
      wr1_data      = $urandom();
      for (int p = 0; p < 3; p++) rd_addr[p] = rand_addr();
      settle(1'b1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
